// File: rtl/mcpu_pkg.sv
// Shared constants for the multi-cycle MIPS control unit.
// State codes, opcode/funct values, ALU and mux select encodings.
package mcpu_pkg;

  typedef enum logic [4:0] {
    S_IF     = 5'd0,
    S_ID     = 5'd1,
    S_EX_R   = 5'd2,
    S_EX_MEM = 5'd3,
    S_EX_I   = 5'd4,
    S_LUI_WB = 5'd5,
    S_EX_BEQ = 5'd6,
    S_EX_BNE = 5'd7,
    S_EX_JR  = 5'd8,
    S_EX_JAL = 5'd9,
    S_EX_J   = 5'd10,
    S_MEM_RD = 5'd11,
    S_MEM_WD = 5'd12,
    S_WB_R   = 5'd13,
    S_WB_I   = 5'd14,
    S_WB_LW  = 5'd15,
    S_ERROR  = 5'd31
  } state_t;

  localparam logic [5:0] OP_R     = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_JR   = 6'b001000;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_XOR = 3'b011;
  localparam logic [2:0] ALU_NOR = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] DST_RT = 2'b00;
  localparam logic [1:0] DST_RD = 2'b01;
  localparam logic [1:0] DST_RA = 2'b10;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MDR = 2'b01;
  localparam logic [1:0] WB_PC  = 2'b10;
  localparam logic [1:0] WB_LUI = 2'b11;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_BOFS = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_REGA   = 2'b11;

  function automatic logic [2:0] funct_alu(input logic [5:0] fn);
    logic [2:0] r;
    r = ALU_ADD;
    case (fn)
      FN_SUB, FN_SUBU: r = ALU_SUB;
      FN_AND:          r = ALU_AND;
      FN_OR:           r = ALU_OR;
      FN_XOR:          r = ALU_XOR;
      FN_NOR:          r = ALU_NOR;
      FN_SLT, FN_SLTU: r = ALU_SLT;
      FN_SRL:          r = ALU_SRL;
      default:         r = ALU_ADD;
    endcase
    return r;
  endfunction

  function automatic logic [2:0] imm_alu(input logic [5:0] op);
    logic [2:0] r;
    r = ALU_ADD;
    case (op)
      OP_SLTI: r = ALU_SLT;
      OP_ANDI: r = ALU_AND;
      OP_ORI:  r = ALU_OR;
      OP_XORI: r = ALU_XOR;
      default: r = ALU_ADD;
    endcase
    return r;
  endfunction

  function automatic state_t dispatch(
    input logic [5:0] op,
    input logic [5:0] fn
  );
    state_t s;
    s = S_ERROR;
    case (op)
      OP_R: begin
        case (fn)
          FN_JR: s = S_EX_JR;
          FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
          FN_AND, FN_OR, FN_XOR, FN_NOR,
          FN_SLT, FN_SLTU, FN_SRL: s = S_EX_R;
          default: s = S_ERROR;
        endcase
      end
      OP_LW, OP_SW: s = S_EX_MEM;
      OP_ADDI, OP_ADDIU, OP_SLTI,
      OP_ANDI, OP_ORI, OP_XORI: s = S_EX_I;
      OP_LUI: s = S_LUI_WB;
      OP_BEQ: s = S_EX_BEQ;
      OP_BNE: s = S_EX_BNE;
      OP_J:   s = S_EX_J;
      OP_JAL: s = S_EX_JAL;
      default: s = S_ERROR;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mcpu_ctrl.sv
// Multi-cycle MIPS control FSM.
// Holds only the state register; all outputs decode from state and IR.
module mcpu_ctrl
  import mcpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Inst_in,
  input  logic        zero,
  input  logic        overflow,
  input  logic        MIO_ready,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [2:0]  ALU_operation,
  output logic [4:0]  state_out,
  output logic        CPU_MIO,
  output logic        IorD,
  output logic        IRWrite,
  output logic [1:0]  RegDst,
  output logic        RegWrite,
  output logic [1:0]  MemtoReg,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  PCSource,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        Branch
);

  state_t     state_q;
  state_t     state_d;
  logic [5:0] op;
  logic [5:0] fn;
  logic       unused_in;

  assign op        = Inst_in[31:26];
  assign fn        = Inst_in[5:0];
  assign state_out = state_q;
  // zero is applied by the datapath; overflow is reserved
  assign unused_in = ^{zero, overflow, Inst_in[25:6]};

  // State register; reset overrides any pending transition
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IF;
    else       state_q <= state_d;
  end

  // Next-state and output decode
  always_comb begin
    state_d       = state_q;
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    ALU_operation = ALU_ADD;
    CPU_MIO       = 1'b0;
    IorD          = 1'b0;
    IRWrite       = 1'b0;
    RegDst        = DST_RT;
    RegWrite      = 1'b0;
    MemtoReg      = WB_ALU;
    ALUSrcA       = 1'b0;
    ALUSrcB       = SRCB_REG;
    PCSource      = PC_ALU;
    PCWrite       = 1'b0;
    PCWriteCond   = 1'b0;
    Branch        = 1'b0;
    unique case (state_q)
      S_IF: begin
        MemRead = 1'b1;
        CPU_MIO = 1'b1;
        ALUSrcB = SRCB_FOUR;
        IRWrite = MIO_ready;
        PCWrite = MIO_ready;
        if (MIO_ready) state_d = S_ID;
      end
      S_ID: begin
        ALUSrcB = SRCB_BOFS;
        state_d = dispatch(op, fn);
      end
      S_EX_R: begin
        ALUSrcA       = 1'b1;
        ALU_operation = funct_alu(fn);
        state_d       = S_WB_R;
      end
      S_WB_R: begin
        ALUSrcA       = 1'b1;
        ALU_operation = funct_alu(fn);
        RegDst        = DST_RD;
        RegWrite      = 1'b1;
        state_d       = S_IF;
      end
      S_EX_I: begin
        ALUSrcA       = 1'b1;
        ALUSrcB       = SRCB_IMM;
        ALU_operation = imm_alu(op);
        state_d       = S_WB_I;
      end
      S_WB_I: begin
        RegWrite = 1'b1;
        state_d  = S_IF;
      end
      S_EX_MEM: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        state_d = (op == OP_SW) ? S_MEM_WD : S_MEM_RD;
      end
      S_MEM_RD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        CPU_MIO = 1'b1;
        if (MIO_ready) state_d = S_WB_LW;
      end
      S_MEM_WD: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        CPU_MIO  = 1'b1;
        if (MIO_ready) state_d = S_IF;
      end
      S_WB_LW: begin
        MemtoReg = WB_MDR;
        RegWrite = 1'b1;
        state_d  = S_IF;
      end
      S_LUI_WB: begin
        MemtoReg = WB_LUI;
        RegWrite = 1'b1;
        state_d  = S_IF;
      end
      S_EX_BEQ, S_EX_BNE: begin
        ALUSrcA       = 1'b1;
        ALU_operation = ALU_SUB;
        PCSource      = PC_ALUOUT;
        PCWriteCond   = 1'b1;
        Branch        = (state_q == S_EX_BEQ);
        state_d       = S_IF;
      end
      S_EX_J: begin
        PCSource = PC_JUMP;
        PCWrite  = 1'b1;
        state_d  = S_IF;
      end
      S_EX_JR: begin
        PCSource = PC_REGA;
        PCWrite  = 1'b1;
        state_d  = S_IF;
      end
      S_EX_JAL: begin
        PCSource = PC_JUMP;
        PCWrite  = 1'b1;
        RegDst   = DST_RA;
        MemtoReg = WB_PC;
        RegWrite = 1'b1;
        state_d  = S_IF;
      end
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_ERROR;
    endcase
  end

endmodule

// File: tb/tb_mcpu_ctrl.sv
// Directed bench for the multi-cycle control FSM.
// Walks instruction classes through their state sequences.
module tb_mcpu_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Inst_in;
  logic        zero;
  logic        overflow;
  logic        MIO_ready;
  logic        MemRead;
  logic        MemWrite;
  logic [2:0]  ALU_operation;
  logic [4:0]  state_out;
  logic        CPU_MIO;
  logic        IorD;
  logic        IRWrite;
  logic [1:0]  RegDst;
  logic        RegWrite;
  logic [1:0]  MemtoReg;
  logic        ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [1:0]  PCSource;
  logic        PCWrite;
  logic        PCWriteCond;
  logic        Branch;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mcpu_ctrl dut (
    .clk(clk),
    .reset(reset),
    .Inst_in(Inst_in),
    .zero(zero),
    .overflow(overflow),
    .MIO_ready(MIO_ready),
    .MemRead(MemRead),
    .MemWrite(MemWrite),
    .ALU_operation(ALU_operation),
    .state_out(state_out),
    .CPU_MIO(CPU_MIO),
    .IorD(IorD),
    .IRWrite(IRWrite),
    .RegDst(RegDst),
    .RegWrite(RegWrite),
    .MemtoReg(MemtoReg),
    .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB),
    .PCSource(PCSource),
    .PCWrite(PCWrite),
    .PCWriteCond(PCWriteCond),
    .Branch(Branch)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    Inst_in   = 32'h0;
    zero      = 1'b0;
    overflow  = 1'b0;
    MIO_ready = 1'b0;
    tick();
    reset = 1'b0;
    check("rst_state", state_out, 0);
    check("rst_irw", IRWrite, 0);
    check("rst_pcw", PCWrite, 0);
    check("rst_mrd", MemRead, 1);
    check("rst_mio", CPU_MIO, 1);
    check("rst_srcb", ALUSrcB, 2'b01);
    tick();
    check("if_hold", state_out, 0);

    // beq
    Inst_in   = 32'h11720052;
    MIO_ready = 1'b1;
    #1;
    check("if_irw", IRWrite, 1);
    check("if_pcw", PCWrite, 1);
    tick();
    check("beq_id", state_out, 1);
    check("id_srcb", ALUSrcB, 2'b11);
    check("id_srca", ALUSrcA, 0);
    tick();
    check("beq_st", state_out, 6);
    check("beq_pwc", PCWriteCond, 1);
    check("beq_br", Branch, 1);
    check("beq_alu", ALU_operation, 3'b110);
    check("beq_pcs", PCSource, 2'b01);
    check("beq_pcw", PCWrite, 0);
    tick();
    check("beq_if", state_out, 0);

    // bne
    Inst_in = 32'h14000000;
    tick();
    tick();
    check("bne_st", state_out, 7);
    check("bne_br", Branch, 0);
    check("bne_pwc", PCWriteCond, 1);
    tick();

    // lw with a memory wait
    Inst_in = 32'h8c000000;
    tick();
    check("lw_id", state_out, 1);
    tick();
    check("lw_ex", state_out, 3);
    check("lw_srcb", ALUSrcB, 2'b10);
    check("lw_alu", ALU_operation, 3'b010);
    MIO_ready = 1'b0;
    tick();
    check("lw_mem", state_out, 11);
    tick();
    check("lw_wait", state_out, 11);
    check("lw_iord", IorD, 1);
    check("lw_mrd", MemRead, 1);
    MIO_ready = 1'b1;
    tick();
    check("lw_wb", state_out, 15);
    check("lw_rw", RegWrite, 1);
    check("lw_m2r", MemtoReg, 2'b01);
    check("lw_dst", RegDst, 2'b00);
    tick();
    check("lw_if", state_out, 0);

    // sw
    Inst_in = 32'hac000000;
    tick();
    tick();
    tick();
    check("sw_mem", state_out, 12);
    check("sw_mwr", MemWrite, 1);
    check("sw_mrd", MemRead, 0);
    tick();
    check("sw_if", state_out, 0);

    // R-type sub
    Inst_in = 32'h00000022;
    tick();
    tick();
    check("sub_ex", state_out, 2);
    check("sub_alu", ALU_operation, 3'b110);
    check("sub_srca", ALUSrcA, 1);
    tick();
    check("sub_wb", state_out, 13);
    check("sub_alu2", ALU_operation, 3'b110);
    check("sub_dst", RegDst, 2'b01);
    check("sub_rw", RegWrite, 1);
    tick();
    check("sub_if", state_out, 0);

    // R-type srl
    Inst_in = 32'h00000002;
    tick();
    tick();
    check("srl_alu", ALU_operation, 3'b101);
    tick();
    tick();

    // ori
    Inst_in = 32'h34000000;
    tick();
    tick();
    check("ori_ex", state_out, 4);
    check("ori_alu", ALU_operation, 3'b001);
    check("ori_srcb", ALUSrcB, 2'b10);
    tick();
    check("ori_wb", state_out, 14);
    check("ori_rw", RegWrite, 1);
    tick();

    // lui
    Inst_in = 32'h3c000000;
    tick();
    tick();
    check("lui_st", state_out, 5);
    check("lui_m2r", MemtoReg, 2'b11);
    tick();

    // jal
    Inst_in = 32'h0c000000;
    tick();
    tick();
    check("jal_st", state_out, 9);
    check("jal_pcw", PCWrite, 1);
    check("jal_pcs", PCSource, 2'b10);
    check("jal_dst", RegDst, 2'b10);
    check("jal_m2r", MemtoReg, 2'b10);
    check("jal_rw", RegWrite, 1);
    tick();

    // jr
    Inst_in = 32'h00000008;
    tick();
    tick();
    check("jr_st", state_out, 8);
    check("jr_pcs", PCSource, 2'b11);
    tick();

    // j
    Inst_in = 32'h08000000;
    tick();
    tick();
    check("j_st", state_out, 10);
    tick();

    // reset during a memory wait
    Inst_in = 32'h8c000000;
    tick();
    tick();
    MIO_ready = 1'b0;
    tick();
    check("rstm_mem", state_out, 11);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rstm_if", state_out, 0);

    // illegal R-type funct
    MIO_ready = 1'b1;
    Inst_in   = 32'h0000003f;
    tick();
    tick();
    check("badfn_st", state_out, 31);
    reset = 1'b1;
    tick();
    reset = 1'b0;

    // illegal opcode sticks until reset
    Inst_in = 32'hfc000000;
    tick();
    tick();
    check("err_st", state_out, 31);
    tick();
    tick();
    check("err_hold", state_out, 31);
    check("err_rw", RegWrite, 0);
    check("err_pcw", PCWrite, 0);
    check("err_mrd", MemRead, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("err_rst", state_out, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
